// File: rtl/pacman_pkg.sv
// pacman_pkg: shared types for the Pacman movement stage.
// Directions, tile width, FSM states.
package pacman_pkg;

  localparam int TILE_W = 5;

  typedef logic [TILE_W-1:0] tile_t;
  typedef logic [1:0]        dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_LEFT  = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN_Q,
    S_TURN_W,
    S_FWD_Q,
    S_FWD_W,
    S_DONE
  } state_t;

endpackage

// File: rtl/pacman_mover_if.sv
// pacman_mover_if: frame tick, turn requests, map port, position out.
// slave = mover side, master = player/map/renderer side.
interface pacman_mover_if;
  import pacman_pkg::*;

  logic  ce;
  logic  req_valid;
  dir_t  req_dir;
  tile_t map_x;
  tile_t map_y;
  logic  map_wall;
  tile_t xpos;
  tile_t ypos;
  dir_t  direction;
  logic  moved;
  logic  blocked;

  modport slave (
    input  ce, req_valid, req_dir, map_wall,
    output map_x, map_y, xpos, ypos,
    output direction, moved, blocked
  );

  modport master (
    output ce, req_valid, req_dir, map_wall,
    input  map_x, map_y, xpos, ypos,
    input  direction, moved, blocked
  );

endinterface

// File: rtl/pacman_step_calc.sv
// pacman_step_calc: next tile for (x,y,dir) and its legality.
// In: x, y, dir, wall. Out: nx, ny, legal. Macro PACMAN_MOVER_TUNNEL_EN.
module pacman_step_calc
  import pacman_pkg::*;
#(
  parameter int BORDER_X_MIN = 1,
  parameter int BORDER_X_MAX = 28,
  parameter int BORDER_Y_MIN = 1,
  parameter int BORDER_Y_MAX = 28,
  parameter int TUNNEL_ROW   = 14
) (
  input  tile_t x,
  input  tile_t y,
  input  dir_t  dir,
  input  logic  wall,
  output tile_t nx,
  output tile_t ny,
  output logic  legal
);

`ifdef PACMAN_MOVER_TUNNEL_EN
  localparam bit TUNNEL_EN = 1'b1;
`else
  localparam bit TUNNEL_EN = 1'b0;
`endif

  localparam tile_t XMIN = tile_t'(BORDER_X_MIN);
  localparam tile_t XMAX = tile_t'(BORDER_X_MAX);
  localparam tile_t YMIN = tile_t'(BORDER_Y_MIN);
  localparam tile_t YMAX = tile_t'(BORDER_Y_MAX);
  localparam tile_t XWL  = tile_t'(BORDER_X_MIN + 1);
  localparam tile_t XWR  = tile_t'(BORDER_X_MAX - 1);
  localparam tile_t TROW = tile_t'(TUNNEL_ROW);

  logic wrap_l;
  logic wrap_r;
  logic in_border;

  assign wrap_l = TUNNEL_EN && (y == TROW) &&
                  (dir == DIR_LEFT) && (x == XWL);
  assign wrap_r = TUNNEL_EN && (y == TROW) &&
                  (dir == DIR_RIGHT) && (x == XWR);

  always_comb begin
    nx = x;
    ny = y;
    unique case (1'b1)
      dir == DIR_UP:   ny = y - 1'b1;
      dir == DIR_LEFT: nx = x - 1'b1;
      dir == DIR_DOWN: ny = y + 1'b1;
      default:         nx = x + 1'b1;
    endcase
    // Tunnel wrap overrides the plain step.
    if (wrap_l) nx = XWR;
    if (wrap_r) nx = XWL;
  end

  assign in_border = (nx > XMIN) && (nx < XMAX) &&
                     (ny > YMIN) && (ny < YMAX);

  // Tunnel moves skip the map; border misses ignore it.
  assign legal = wrap_l || wrap_r || (in_border && !wall);

endmodule

// File: rtl/pacman_mover.sv
// pacman_mover: paces Pacman steps, buffers turns, checks walls.
// Ports: clk, reset (async, high), bus (pacman_mover_if.slave).
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int BORDER_X_MIN = 1,
  parameter int BORDER_X_MAX = 28,
  parameter int BORDER_Y_MIN = 1,
  parameter int BORDER_Y_MAX = 28,
  parameter int START_X      = 2,
  parameter int START_Y      = 2,
  parameter int START_DIR    = 3,
  parameter int MOVE_PERIOD  = 15,
  parameter int TUNNEL_ROW   = 14
) (
  input logic           clk,
  input logic           reset,
  pacman_mover_if.slave bus
);

  localparam int CW = $clog2(MOVE_PERIOD + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(MOVE_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  state_t state, state_n;
  tile_t  x, y, mx, my, qx, qy;
  tile_t  tnx, tny, fnx, fny;
  dir_t   dir, pd, try_dir, turn_dir;
  logic   pv, blk;
  logic   t_ok, f_ok;
  logic   ld_q, take_turn, take_fwd;
  logic   drop_pv, set_blk, clr_blk;

  assign tick = bus.ce && (cnt >= CNT_TOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.ce) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  // The turn direction is frozen at the attempt so a late
  // request cannot mismatch the map answer in flight.
  assign turn_dir = (state == S_IDLE) ? pd : try_dir;

  pacman_step_calc #(
    .BORDER_X_MIN(BORDER_X_MIN),
    .BORDER_X_MAX(BORDER_X_MAX),
    .BORDER_Y_MIN(BORDER_Y_MIN),
    .BORDER_Y_MAX(BORDER_Y_MAX),
    .TUNNEL_ROW  (TUNNEL_ROW)
  ) u_turn (
    .x    (x),
    .y    (y),
    .dir  (turn_dir),
    .wall (bus.map_wall),
    .nx   (tnx),
    .ny   (tny),
    .legal(t_ok)
  );

  pacman_step_calc #(
    .BORDER_X_MIN(BORDER_X_MIN),
    .BORDER_X_MAX(BORDER_X_MAX),
    .BORDER_Y_MIN(BORDER_Y_MIN),
    .BORDER_Y_MAX(BORDER_Y_MAX),
    .TUNNEL_ROW  (TUNNEL_ROW)
  ) u_fwd (
    .x    (x),
    .y    (y),
    .dir  (dir),
    .wall (bus.map_wall),
    .nx   (fnx),
    .ny   (fny),
    .legal(f_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ld_q      = 1'b0;
    qx        = mx;
    qy        = my;
    take_turn = 1'b0;
    take_fwd  = 1'b0;
    drop_pv   = 1'b0;
    set_blk   = 1'b0;
    clr_blk   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick) begin
          ld_q = 1'b1;
          if (pv && (pd != dir)) begin
            state_n = S_TURN_Q;
            qx      = tnx;
            qy      = tny;
          end else begin
            state_n = S_FWD_Q;
            qx      = fnx;
            qy      = fny;
            drop_pv = pv;
          end
        end
      end
      S_TURN_Q: state_n = S_TURN_W;
      S_TURN_W: begin
        if (t_ok) begin
          take_turn = 1'b1;
          drop_pv   = (pd == try_dir);
          state_n   = S_DONE;
        end else begin
          ld_q    = 1'b1;
          qx      = fnx;
          qy      = fny;
          state_n = S_FWD_Q;
        end
      end
      S_FWD_Q: state_n = S_FWD_W;
      S_FWD_W: begin
        if (f_ok) begin
          take_fwd = 1'b1;
          state_n  = S_DONE;
        end else begin
          set_blk = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DONE: begin
        clr_blk = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= tile_t'(START_X);
      y       <= tile_t'(START_Y);
      dir     <= dir_t'(START_DIR);
      mx      <= '0;
      my      <= '0;
      pv      <= 1'b0;
      pd      <= '0;
      try_dir <= '0;
      blk     <= 1'b0;
    end else begin
      if (ld_q) begin
        mx <= qx;
        my <= qy;
      end
      if (state == S_IDLE && tick) try_dir <= pd;
      if (take_turn) begin
        dir <= try_dir;
        x   <= tnx;
        y   <= tny;
      end
      if (take_fwd) begin
        x <= fnx;
        y <= fny;
      end
      if (set_blk)      blk <= 1'b1;
      else if (clr_blk) blk <= 1'b0;
      // A fresh request always beats consumption.
      if (bus.req_valid) begin
        pv <= 1'b1;
        pd <= bus.req_dir;
      end else if (drop_pv) begin
        pv <= 1'b0;
      end
    end
  end

  assign bus.map_x     = mx;
  assign bus.map_y     = my;
  assign bus.xpos      = x;
  assign bus.ypos      = y;
  assign bus.direction = dir;
  assign bus.moved     = (state == S_DONE);
  assign bus.blocked   = blk;

endmodule

// File: doc/pacman_mover.md
Name: pacman_mover

Overview:
- Upstream movement stage for the Pacman sprite renderer.
- Owns Pacman's tile position (xpos, ypos) and facing direction; the renderer consumes these outputs directly.
- Buffers player turn requests, paces steps from the frame-enable tick, and checks wall tiles through a 1-cycle-latency map port before committing each step.

Parameters:
- BORDER_X_MIN, 1: x must stay strictly greater than this.
- BORDER_X_MAX, 28: x must stay strictly less than this.
- BORDER_Y_MIN, 1: y lower exclusive bound.
- BORDER_Y_MAX, 28: y upper exclusive bound.
- START_X, 2: reset x tile.
- START_Y, 2: reset y tile.
- START_DIR, 3: reset direction (right).
- MOVE_PERIOD, 15: ce ticks per step attempt.
- TUNNEL_ROW, 14: y row used by the optional tunnel feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  frame tick, one-cycle pulse.
- req_valid  in  1  player turn request strobe.
- req_dir  in  2  requested direction: 0 up, 1 left, 2 down, 3 right.
- map_x  out  5  tile x being queried.
- map_y  out  5  tile y being queried.
- map_wall  in  1  wall flag for (map_x, map_y); valid exactly 1 clk after the query is presented.
- xpos  out  5  current tile x.
- ypos  out  5  current tile y.
- direction  out  2  current facing direction (same encoding as req_dir).
- moved  out  1  1-cycle pulse on each committed step.
- blocked  out  1  level; set when the last step attempt failed.

Behaviour:
- Reset values: xpos=START_X, ypos=START_Y, direction=START_DIR, moved=0, blocked=0, pending_valid=0, tick counter=0, FSM=IDLE, map_x/map_y=0.
- Tick counter:
  - Counts only when ce=1.
  - When counter ≥ MOVE_PERIOD-1 and ce=1: counter←0 and a step attempt is raised.
  - A step attempt raised while the FSM is not IDLE is dropped; no queueing.
- Request buffer:
  - req_valid=1 latches pending_dir←req_dir and pending_valid←1; a newer request overwrites the old one.
  - If req_valid coincides with the FSM consuming pending, the new request wins: pending stays valid with the new value.
- Next tile: nxt(d) = x-1 for d=1, x+1 for d=3, y-1 for d=0, y+1 for d=2, computed in 5-bit arithmetic.
- Legal tile: the candidate satisfies BORDER_MIN < coord < BORDER_MAX on both axes and map_wall=0. Out-of-border candidates fail without waiting for the map result; the FSM still takes the WAIT cycle, for fixed timing.
- FSM:
  - IDLE → TURN_Q on a step attempt if pending_valid and pending_dir≠direction; otherwise → FWD_Q.
  - TURN_Q: drive map_x/map_y = nxt(pending_dir) → TURN_W.
  - TURN_W:
    - If legal: direction←pending_dir, position←candidate, pending_valid←0 → DONE.
    - Otherwise: pending stays valid → FWD_Q.
  - FWD_Q: drive nxt(direction) → FWD_W.
  - FWD_W: if legal, position←candidate → DONE; otherwise blocked←1 → IDLE.
  - DONE: moved=1 for this cycle, blocked←0 → IDLE.
- pending_dir equal to direction is cleared on consumption and proceeds straight to FWD_Q.
- Latency: step attempt to moved pulse is 3 clk (forward only) or 3 clk (turn succeeded); a failed turn followed by a forward step takes 5 clk.
- map_x/map_y hold their last query value while in IDLE.
- Reset asserted mid-sequence: the FSM returns to IDLE immediately and any partial step is discarded.
- ce has no effect on FSM progress; only the tick counter uses ce.

Optional Feature:
- Macro: PACMAN_MOVER_TUNNEL_EN.
- Defined: when ypos==TUNNEL_ROW, a horizontal move is handled as follows, with no map check and marked legal:
  - direction 1 with x==BORDER_X_MIN+1 wraps to BORDER_X_MAX-1.
  - direction 3 with x==BORDER_X_MAX-1 wraps to BORDER_X_MIN+1.
- Undefined: the border check applies everywhere, and these moves fail.

Decomposition:
- Shared package pacman_pkg:
  - Direction constants DIR_UP=0, DIR_LEFT=1, DIR_DOWN=2, DIR_RIGHT=3.
  - FSM state enum.
  - Tile coordinate width constant (5).
- Sub-module pacman_step_calc: combinational nxt() plus border/tunnel legality. It is shared by the turn and forward paths, and ghosts will reuse it later.

Test Plan:
- Reset with MOVE_PERIOD=15 and all map_wall=0 → after 15 ce pulses, moved pulses exactly once 3 clk later; xpos=3, ypos=2.
- At (5,5), direction=3, req_dir=0, map wall at (5,4) → the turn fails, the forward step moves to (6,5), pending is kept; after the wall is cleared, the next attempt gives direction=0 at (6,4).
- At (27,10), direction=3 → no map dependence: blocked=1, xpos stays 27, no moved pulse.
- req_valid with dir=2 then dir=1 in consecutive cycles before a tick → only dir=1 is attempted (check via the map_x/map_y query sequence).
- Reset asserted in TURN_W → outputs return to (2,2,3) asynchronously, no moved pulse, counter=0.
- With PACMAN_MOVER_TUNNEL_EN defined, at (2,14) with direction=1 → next step gives xpos=27, ypos=14 and moved=1. Undefined → blocked=1.
